// File: rtl/fp_divider_seq_if.sv
// Start/done handshake and result bundle for the sequential FP divider.
// The master drives the operands and start; the slave returns the result and flags.
interface fp_divider_seq_if #(
  parameter int X = 32
);
  logic         start;
  logic [X-1:0] A;
  logic [X-1:0] B;
  logic [X-1:0] out;
  logic         busy;
  logic         done;
  logic         overflow_flag;
  logic         underflow_flag;
  logic         div_by_zero_flag;

  modport master (
    output start, A, B,
    input  out, busy, done, overflow_flag, underflow_flag, div_by_zero_flag
  );

  modport slave (
    input  start, A, B,
    output out, busy, done, overflow_flag, underflow_flag, div_by_zero_flag
  );
endinterface

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 divider (A / B) using a restoring mantissa divider, one quotient bit per cycle.
// Optional macro FP_DIV_ROUND_NEAREST_EN: one extra quotient bit and round-to-nearest-even (default truncates).
module fp_divider_seq #(
  parameter int X = 32
) (
  input logic             clk,
  input logic             rst_n,
  fp_divider_seq_if.slave bus
);

  localparam int EXP_BITS  = (X == 64) ? 11 : 8;
  localparam int MANT_BITS = X - EXP_BITS - 1;
  localparam int BIAS      = (1 << (EXP_BITS - 1)) - 1;
`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int N         = MANT_BITS + 3;
`else
  localparam int N         = MANT_BITS + 2;
`endif
  localparam int EW        = EXP_BITS + 2;
  localparam int RW        = MANT_BITS + 3;
  localparam int CW        = $clog2(N + 1);

  localparam logic [X-1:0] QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_BITS) - 1);

  typedef enum logic [1:0] {IDLE, SPECIAL, DIV, NORM} state_t;

  state_t                 state;
  logic                   sign_reg;
  logic signed [EW-1:0]   e_reg;
  logic [MANT_BITS:0]     mb_reg;
  logic [RW-1:0]          rem_reg;
  logic [N-1:0]           q_reg;
  logic [CW-1:0]          cnt;
  logic [X-1:0]           spec_out_reg;
  logic                   spec_dbz_reg;

  // Operand classification on the live bus, used only on the accept edge
  logic [EXP_BITS-1:0]    exp_a, exp_b;
  logic [MANT_BITS-1:0]   man_a, man_b;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                   sign_in;
  logic signed [EW-1:0]   e_in;

  assign exp_a   = bus.A[X-2:MANT_BITS];
  assign exp_b   = bus.B[X-2:MANT_BITS];
  assign man_a   = bus.A[MANT_BITS-1:0];
  assign man_b   = bus.B[MANT_BITS-1:0];
  assign a_nan   = (&exp_a) & (|man_a);
  assign b_nan   = (&exp_b) & (|man_b);
  assign a_inf   = (&exp_a) & ~(|man_a);
  assign b_inf   = (&exp_b) & ~(|man_b);
  assign a_zero  = ~(|exp_a);
  assign b_zero  = ~(|exp_b);
  assign sign_in = bus.A[X-1] ^ bus.B[X-1];
  assign e_in    = EW'(exp_a) - EW'(exp_b) + EW'(BIAS);

  logic         spec_hit;
  logic         spec_dbz;
  logic [X-1:0] spec_out;

  // Priority order matters: NaN-producing cases first, then infinities, then zeros
  always_comb begin
    spec_hit = 1'b1;
    spec_dbz = 1'b0;
    spec_out = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_out = QNAN;
    end else if (a_inf | b_zero) begin
      spec_out = {sign_in, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      spec_dbz = b_zero & ~a_inf;
    end else if (a_zero | b_inf) begin
      spec_out = {sign_in, {(X-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic          rem_ge;
  logic [RW-1:0] rem_diff;
  logic [RW-1:0] rem_shift;

  assign rem_ge    = rem_reg >= RW'(mb_reg);
  assign rem_diff  = rem_ge ? (rem_reg - RW'(mb_reg)) : rem_reg;
  assign rem_shift = {rem_diff[RW-2:0], 1'b0};

  logic [MANT_BITS-1:0] mant_n;
  logic signed [EW-1:0] e_n;
  logic                 norm_ovf;
  logic                 norm_unf;
  logic [X-1:0]         norm_out;
`ifdef FP_DIV_ROUND_NEAREST_EN
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [MANT_BITS:0]   mant_sum;
`endif

  // Quotient lies in (0.5, 2): a clear top bit means one extra normalising shift
  always_comb begin
    mant_n = '0;
    e_n    = e_reg;
`ifdef FP_DIV_ROUND_NEAREST_EN
    guard_bit  = 1'b0;
    sticky_bit = 1'b0;
    round_up   = 1'b0;
    mant_sum   = '0;
`endif
    if (q_reg[N-1]) begin
      mant_n = q_reg[N-2 -: MANT_BITS];
`ifdef FP_DIV_ROUND_NEAREST_EN
      guard_bit  = q_reg[1];
      sticky_bit = q_reg[0] | (|rem_reg);
`endif
    end else begin
      mant_n = q_reg[N-3 -: MANT_BITS];
      e_n    = e_reg - EW'(1);
`ifdef FP_DIV_ROUND_NEAREST_EN
      guard_bit  = q_reg[0];
      sticky_bit = |rem_reg;
`endif
    end
`ifdef FP_DIV_ROUND_NEAREST_EN
    round_up = guard_bit & (sticky_bit | mant_n[0]);
    mant_sum = {1'b0, mant_n} + (MANT_BITS+1)'(round_up);
    mant_n   = mant_sum[MANT_BITS-1:0];
    if (mant_sum[MANT_BITS]) begin
      e_n = e_n + EW'(1);
    end
`endif
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (e_n >= EMAX) begin
      norm_ovf = 1'b1;
      norm_out = {sign_reg, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
    end else if (e_n[EW-1] || (e_n == '0)) begin
      norm_unf = 1'b1;
      norm_out = {sign_reg, {(X-1){1'b0}}};
    end else begin
      norm_out = {sign_reg, e_n[EXP_BITS-1:0], mant_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      sign_reg             <= 1'b0;
      e_reg                <= '0;
      mb_reg               <= '0;
      rem_reg              <= '0;
      q_reg                <= '0;
      cnt                  <= '0;
      spec_out_reg         <= '0;
      spec_dbz_reg         <= 1'b0;
      bus.out              <= '0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.overflow_flag    <= 1'b0;
      bus.underflow_flag   <= 1'b0;
      bus.div_by_zero_flag <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            sign_reg <= sign_in;
            if (spec_hit) begin
              spec_out_reg <= spec_out;
              spec_dbz_reg <= spec_dbz;
              state        <= SPECIAL;
            end else begin
              e_reg   <= e_in;
              mb_reg  <= {1'b1, man_b};
              rem_reg <= RW'({1'b1, man_a});
              q_reg   <= '0;
              cnt     <= CW'(N - 1);
              state   <= DIV;
            end
          end
        end
        SPECIAL: begin
          bus.out              <= spec_out_reg;
          bus.overflow_flag    <= 1'b0;
          bus.underflow_flag   <= 1'b0;
          bus.div_by_zero_flag <= spec_dbz_reg;
          bus.done             <= 1'b1;
          bus.busy             <= 1'b0;
          state                <= IDLE;
        end
        DIV: begin
          q_reg   <= {q_reg[N-2:0], rem_ge};
          rem_reg <= rem_shift;
          if (cnt == '0) begin
            state <= NORM;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        NORM: begin
          bus.out              <= norm_out;
          bus.overflow_flag    <= norm_ovf;
          bus.underflow_flag   <= norm_unf;
          bus.div_by_zero_flag <= 1'b0;
          bus.done             <= 1'b1;
          bus.busy             <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
